// File: rtl/palette_arbiter_if.sv
// Pixel-request / arbitrated-colour bundle between the game renderer and the
// palette arbiter.
interface palette_arbiter_if;
  logic       pixel_valid;
  logic       frame_start;
  logic [3:0] bg_idx;
  logic       p1_req;
  logic [3:0] p1_idx;
  logic       p2_req;
  logic [3:0] p2_idx;
  logic       ovl_req;
  logic [3:0] ovl_idx;
  logic       crash;
  logic       crash_id;
  logic       paused;
  logic [3:0] color_pallete_enum;
  logic       out_valid;
  logic       flash_busy;

  modport master (
    output pixel_valid, frame_start, bg_idx,
    output p1_req, p1_idx, p2_req, p2_idx, ovl_req, ovl_idx,
    output crash, crash_id, paused,
    input  color_pallete_enum, out_valid, flash_busy
  );

  modport slave (
    input  pixel_valid, frame_start, bg_idx,
    input  p1_req, p1_idx, p2_req, p2_idx, ovl_req, ovl_idx,
    input  crash, crash_id, paused,
    output color_pallete_enum, out_valid, flash_busy
  );
endinterface

// File: rtl/palette_arbiter.sv
// Two-stage pixel palette arbiter: fixed-priority layer select, then crash
// flash / pause recolouring driven by a frame-counted flash FSM.
module palette_arbiter #(
  parameter int FLASH_HALF   = 8,
  parameter int FLASH_CYCLES = 4
) (
  input logic               Clk,
  input logic               Reset_n,
  palette_arbiter_if.slave  pa
);
  localparam int STAGES = 2;
  localparam int FW = (FLASH_HALF   > 1) ? $clog2(FLASH_HALF)   : 1;
  localparam int CW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
  localparam logic [FW-1:0] HALF_LAST = FW'(FLASH_HALF - 1);
  localparam logic [CW-1:0] CYC_LAST  = CW'(FLASH_CYCLES - 1);
  localparam logic [3:0] IDX_WHITE = 4'd0;
  localparam logic [3:0] IDX_GREY  = 4'd2;
  localparam logic [3:0] IDX_BLACK = 4'd14;

  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;
  typedef enum logic [1:0] {SRC_BG = 2'd0, SRC_P1 = 2'd1, SRC_P2 = 2'd2, SRC_OVL = 2'd3} src_t;
  typedef struct packed {
    logic [3:0] idx;
    src_t       src;
  } pix_t;

  state_t        state, state_nxt;
  logic [FW-1:0] frame_cnt, frame_cnt_nxt;
  logic [CW-1:0] cyc_cnt, cyc_cnt_nxt;
  logic          flash_id, flash_id_nxt;
  logic          frame_tick;

  // A paused frame does not count, so the flash freezes where it is.
  assign frame_tick = pa.frame_start & ~pa.paused;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      frame_cnt <= '0;
      cyc_cnt   <= '0;
      flash_id  <= 1'b0;
    end else begin
      state     <= state_nxt;
      frame_cnt <= frame_cnt_nxt;
      cyc_cnt   <= cyc_cnt_nxt;
      flash_id  <= flash_id_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    frame_cnt_nxt = frame_cnt;
    cyc_cnt_nxt   = cyc_cnt;
    flash_id_nxt  = flash_id;
    unique case (state)
      IDLE: begin
        if (pa.crash) begin
          state_nxt     = ON;
          flash_id_nxt  = pa.crash_id;
          frame_cnt_nxt = '0;
          cyc_cnt_nxt   = '0;
        end
      end
      ON: begin
        if (frame_tick) begin
          if (frame_cnt == HALF_LAST) begin
            state_nxt     = OFF;
            frame_cnt_nxt = '0;
          end else begin
            frame_cnt_nxt = frame_cnt + 1'b1;
          end
        end
      end
      OFF: begin
        if (frame_tick) begin
          if (frame_cnt == HALF_LAST) begin
            frame_cnt_nxt = '0;
            if (cyc_cnt == CYC_LAST) begin
              state_nxt   = IDLE;
              cyc_cnt_nxt = '0;
            end else begin
              state_nxt   = ON;
              cyc_cnt_nxt = cyc_cnt + 1'b1;
            end
          end else begin
            frame_cnt_nxt = frame_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage 1: layer select, overlay on top, background underneath.
  pix_t s1_d, s1_q;

  always_comb begin
    s1_d = '{idx: pa.bg_idx, src: SRC_BG};
    if (pa.ovl_req)     s1_d = '{idx: pa.ovl_idx, src: SRC_OVL};
    else if (pa.p1_req) s1_d = '{idx: pa.p1_idx,  src: SRC_P1};
    else if (pa.p2_req) s1_d = '{idx: pa.p2_idx,  src: SRC_P2};
  end

  logic [STAGES:1] vld_pipe;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vld_pipe <= '0;
      s1_q     <= '{idx: 4'd0, src: SRC_BG};
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], pa.pixel_valid};
      s1_q     <= s1_d;
    end
  end

  // Stage 2: pause greys everything but text; otherwise flash the crashed player.
  logic       flash_hit;
  logic [3:0] s2_idx, out_idx;

  assign flash_hit = (state == ON) &&
                     (((s1_q.src == SRC_P1) && !flash_id) ||
                      ((s1_q.src == SRC_P2) &&  flash_id));

  always_comb begin
    s2_idx = s1_q.idx;
    if (!vld_pipe[1])              s2_idx = IDX_BLACK;
    else if (s1_q.src == SRC_OVL)  s2_idx = s1_q.idx;
    else if (pa.paused)            s2_idx = IDX_GREY;
    else if (flash_hit)            s2_idx = IDX_WHITE;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) out_idx <= IDX_BLACK;
    else          out_idx <= s2_idx;
  end

  assign pa.color_pallete_enum = out_idx;
  assign pa.out_valid          = vld_pipe[STAGES];
  assign pa.flash_busy         = (state != IDLE);
endmodule

// File: tb/tb_palette_arbiter.sv
// Scoreboard bench for palette_arbiter: stimulus pushes expected colours, a
// negedge monitor pops and checks value and two-cycle latency.
module tb_palette_arbiter;
  localparam int FH = 8;
  localparam int FC = 4;
  localparam int FLASH_FRAMES = 2 * FH * FC;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  palette_arbiter_if bus ();

  palette_arbiter #(.FLASH_HALF(FH), .FLASH_CYCLES(FC)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .pa(bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0] idx;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_n  = 0;
  bit   mon_en = 1'b1;

  // reference flash model: frames counted since the crash
  bit m_flash = 1'b0;
  int m_f     = 0;
  bit m_id    = 1'b0;

  initial forever begin
    @(posedge Clk);
    cyc_n++;
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, req, $time);
    end
  endtask

  // monitor
  initial forever begin
    @(negedge Clk);
    if (Reset_n && mon_en) begin
      if (bus.out_valid === 1'b1) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pixel: got idx %0d expected none at t=%0t", bus.color_pallete_enum, $time);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("pixel_idx", bus.color_pallete_enum, e.idx);
          check("pixel_latency", cyc_n, e.cyc + 2);
        end
      end else begin
        check("idle_black", bus.color_pallete_enum, 14);
      end
    end
  end

  function automatic logic [3:0] exp_pix(bit p1r, logic [3:0] p1i, bit p2r, logic [3:0] p2i,
                                         bit ovr, logic [3:0] ovi, logic [3:0] bg, bit pz);
    bit on;
    on = m_flash && (((m_f / FH) % 2) == 0);
    if (ovr) return ovi;
    if (pz)  return 4'd2;
    if (p1r) return (on && !m_id) ? 4'd0 : p1i;
    if (p2r) return (on &&  m_id) ? 4'd0 : p2i;
    return bg;
  endfunction

  task automatic idle_inputs();
    bus.pixel_valid = 0; bus.frame_start = 0; bus.crash = 0; bus.crash_id = 0;
    bus.p1_req = 0; bus.p2_req = 0; bus.ovl_req = 0;
    bus.p1_idx = 4'd3; bus.p2_idx = 4'd5; bus.ovl_idx = 4'd15; bus.bg_idx = 4'd7;
  endtask

  task automatic pix(bit p1r, bit p2r, bit ovr);
    exp_t e;
    bus.pixel_valid = 1; bus.p1_req = p1r; bus.p2_req = p2r; bus.ovl_req = ovr;
    e.idx = exp_pix(p1r, bus.p1_idx, p2r, bus.p2_idx, ovr, bus.ovl_idx, bus.bg_idx, bus.paused);
    e.cyc = cyc_n;
    q.push_back(e);
    @(posedge Clk); #1;
    bus.pixel_valid = 0; bus.p1_req = 0; bus.p2_req = 0; bus.ovl_req = 0;
  endtask

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  // one frame: frame_start, four layered pixels, one quiet cycle
  task automatic frame(bit pz);
    bus.paused = pz;
    bus.frame_start = 1;
    if (m_flash && !pz) begin
      m_f++;
      if (m_f == FLASH_FRAMES) m_flash = 0;
    end
    tick();
    bus.frame_start = 0;
    check("flash_busy", bus.flash_busy, m_flash);
    pix(1, 0, 0);
    pix(0, 1, 0);
    pix(1, 1, 1);
    pix(0, 0, 0);
    tick();
  endtask

  task automatic do_crash(bit id, bit with_fs);
    bus.crash = 1; bus.crash_id = id; bus.frame_start = with_fs;
    if (!m_flash) begin
      m_flash = 1; m_f = 0; m_id = id;
    end
    tick();
    bus.crash = 0; bus.frame_start = 0;
    check("flash_busy_crash", bus.flash_busy, m_flash);
  endtask

  initial begin
    idle_inputs();
    bus.paused = 0;
    #12;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_color", bus.color_pallete_enum, 14);
    check("rst_flash_busy", bus.flash_busy, 0);

    // first edge after release carries a pixel
    @(negedge Clk);
    Reset_n = 1;
    pix(1, 0, 1);   // 15
    pix(1, 0, 0);   // 3
    pix(0, 0, 0);   // 7
    pix(0, 1, 0);   // 5
    tick(); tick();

    // flash on player 2, with a stray player-1 crash mid-sequence
    do_crash(1, 0);
    for (int i = 0; i < FLASH_FRAMES + 2; i++) begin
      if (i == 20) do_crash(0, 0);
      frame(0);
    end

    // flash on player 1 entered on a frame_start, paused for 10 frames in ON
    do_crash(0, 1);
    for (int i = 0; i < 3; i++)  frame(0);
    for (int i = 0; i < 10; i++) frame(1);
    for (int i = 0; i < FLASH_FRAMES - 3 + 2; i++) frame(0);

    // flash on player 2, reset in the OFF half with pixels streaming
    do_crash(1, 0);
    for (int i = 0; i < 12; i++) frame(0);
    bus.frame_start = 1; m_f++; tick(); bus.frame_start = 0;
    check("busy_before_reset", bus.flash_busy, 1);
    pix(0, 1, 0);
    bus.pixel_valid = 1; bus.p2_req = 1;
    #2;
    mon_en = 0;
    Reset_n = 0;
    #1;
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_color", bus.color_pallete_enum, 14);
    check("arst_flash_busy", bus.flash_busy, 0);
    q.delete();
    m_flash = 0; m_f = 0;
    tick(); tick();
    check("rst_hold_valid", bus.out_valid, 0);
    @(negedge Clk);
    bus.pixel_valid = 0; bus.p2_req = 0;
    Reset_n = 1;
    mon_en = 1;
    tick();
    for (int i = 0; i < 3; i++) frame(0);

    // drain
    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    check("scoreboard_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
